// File: rtl/spi_2_pkg.sv
// Shared types and constants for the spi_2 link.
package spi_2_pkg;

  // Default link geometry
  localparam int DWIDTH    = 32;
  localparam int AWIDTH    = 8;

  // Command header: WR_EN(1) + SIZE(2)
  localparam int CMD_WIDTH = 3;

  // Slave frame phases
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    DONE
  } spi_slv_state_e;

  // Command header as it arrives, MSB first
  typedef struct packed {
    logic       wr_en;
    logic [1:0] size;
  } spi_slv_cmd_t;

  // Data bits carried by a frame of the given SIZE, clipped to the word width
  function automatic int unsigned size_to_nbits(input logic [1:0] size,
                                                input int unsigned dwidth);
    int unsigned nb;
    nb = 32'd8 << size;
    return (nb > dwidth) ? dwidth : nb;
  endfunction

endpackage

// File: rtl/spi_2_sync_edge.sv
// Synchroniser for one asynchronous input plus rise/fall pulses.
// All stages reset to 0, so a falling pulse can only follow a genuine high
// level that was observed after reset.
module spi_2_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STG-1:0] r_sync;
  logic                r_prev;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage capture the previous
      // stage's old value, which is what makes this a shift chain.
      r_sync <= {r_sync[SYNC_STG-2:0], i_d};
      r_prev <= r_sync[SYNC_STG-1];
    end
  end

  assign o_q    = r_sync[SYNC_STG-1];
  assign o_rise =  o_q & ~r_prev;
  assign o_fall = ~o_q &  r_prev;

endmodule

// File: rtl/spi_2_slave.sv
// SPI slave for the spi_2 link: receives {WR_EN, SIZE, ADDR, WDATA} frames
// into a local register array and serialises read data back on miso.
// sclk, ss_n and mosi are oversampled in the clk domain.
module spi_2_slave #(
  parameter int DWIDTH   = spi_2_pkg::DWIDTH,
  parameter int AWIDTH   = spi_2_pkg::AWIDTH,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cfg,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_pulse,
  output logic              rd_pulse,
  output logic              frame_err,
  input  logic [AWIDTH-1:0] dbg_addr,
  output logic [DWIDTH-1:0] dbg_rdata
);

  import spi_2_pkg::*;

  localparam int DEPTH   = 1 << AWIDTH;
  localparam int CNT_D   = $clog2(DWIDTH + 1);
  localparam int CNT_A   = $clog2(AWIDTH + 1);
  // Counter must hold both the address length and the data length
  localparam int CNT_W   = (CNT_D > CNT_A) ? CNT_D : CNT_A;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Extra samples tolerated in DONE before flagging an overrun
  localparam logic [CNT_W-1:0] EXTRA_MAX = CNT_W'(4);

  // Synchronised pins and edges
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_ss_q,   w_ss_rise,   w_ss_fall;
  logic w_mosi,   w_mosi_rise, w_mosi_fall;

  spi_2_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (sclk),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_2_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (ss_n),
    .o_q    (w_ss_q),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_2_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (mosi),
    .o_q    (w_mosi),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  // Only the level of sclk's edges and mosi's level are consumed
  logic w_unused_sync;
  assign w_unused_sync = ^{w_sclk_q, w_mosi_rise, w_mosi_fall};

  // State and datapath registers
  spi_slv_state_e      r_state, w_state_nxt;
  spi_slv_cmd_t        r_cmd;
  logic                r_cpol, r_cpha;
  logic [CNT_W-1:0]    r_cnt;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_rx;
  logic [DWIDTH-1:0]   r_tx;
  logic                r_miso;
  logic                r_armed;
  logic                r_wr_pend;
  logic                r_wr_pulse, r_rd_pulse, r_frame_err;
  logic [DWIDTH-1:0]   r_mem [DEPTH];

  // Clock edges in the latched mode
  logic w_lead, w_trail, w_sample, w_shift;
  assign w_lead   = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead  : w_trail;

  // Frame geometry derived from the received header
  logic [CNT_W-1:0]  w_nb;
  logic [DWIDTH-1:0] w_mask;
  logic              w_last_cmd, w_last_addr, w_last_data;
  assign w_nb        = CNT_W'(size_to_nbits(r_cmd.size, DWIDTH));
  assign w_mask      = (w_nb == CNT_W'(DWIDTH)) ? '1
                     : ((DWIDTH'(1) << w_nb) - DWIDTH'(1));
  assign w_last_cmd  = (r_cnt == CNT_W'(CMD_WIDTH - 1));
  assign w_last_addr = (r_cnt == CNT_W'(AWIDTH - 1));
  assign w_last_data = (r_cnt == (w_nb - CNT_ONE));

  // Read word: address completes with the bit being sampled right now
  logic [AWIDTH-1:0] w_addr_full;
  logic [DWIDTH-1:0] w_tx_word;
  assign w_addr_full = {r_addr[AWIDTH-2:0], w_mosi};
  assign w_tx_word   = (r_mem[w_addr_full] & w_mask) << (CNT_W'(DWIDTH) - w_nb);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch forms.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_ss_fall) w_state_nxt = CMD;
      CMD: begin
        if (w_ss_rise)                      w_state_nxt = IDLE;
        else if (w_sample && w_last_cmd)    w_state_nxt = ADDR;
      end
      ADDR: begin
        if (w_ss_rise)                      w_state_nxt = IDLE;
        else if (w_sample && w_last_addr)   w_state_nxt = r_cmd.wr_en ? WDATA : RDATA;
      end
      WDATA, RDATA: begin
        if (w_ss_rise)                      w_state_nxt = IDLE;
        else if (w_sample && w_last_data)   w_state_nxt = DONE;
      end
      DONE:  if (w_ss_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame events
  logic w_load_tx, w_wr_done, w_abort, w_overrun, w_in_frame;
  assign w_in_frame = (r_state == CMD) || (r_state == ADDR) ||
                      (r_state == WDATA) || (r_state == RDATA);
  assign w_load_tx  = (r_state == ADDR)  && (w_state_nxt == RDATA);
  assign w_wr_done  = (r_state == WDATA) && (w_state_nxt == DONE);
  assign w_abort    = w_in_frame && w_ss_rise;
  assign w_overrun  = (r_state == DONE) && !w_ss_rise && w_sample && (r_cnt == EXTRA_MAX);

  // Datapath: mode latch, bit counter, RX/TX shifters and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_armed     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_pulse  <= 1'b0;
      r_rd_pulse  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rd_pulse  <= w_load_tx;
      r_wr_pend   <= w_wr_done;
      r_wr_pulse  <= r_wr_pend;
      r_frame_err <= w_abort | w_overrun;

      if (w_ss_rise) r_armed <= 1'b1;

      if ((r_state == IDLE) && w_ss_fall) begin
        r_cpol <= cfg[1];
        r_cpha <= cfg[0];
      end

      // Per-phase sample count; saturates rather than wrapping in DONE
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (w_sample && (r_state != IDLE) && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_ONE;

      if (w_sample) begin
        case (r_state)
          CMD:     r_cmd  <= spi_slv_cmd_t'({r_cmd[1:0], w_mosi});
          ADDR:    r_addr <= w_addr_full;
          WDATA:   r_rx   <= {r_rx[DWIDTH-2:0], w_mosi};
          default: ;
        endcase
      end

      // CPHA=0 presents the first bit immediately; CPHA=1 waits for the next lead
      if (w_load_tx) begin
        r_tx   <= r_cpha ? w_tx_word : (w_tx_word << 1);
        r_miso <= r_cpha ? 1'b0 : w_tx_word[DWIDTH-1];
      end else if ((r_state == RDATA) && (w_state_nxt == RDATA) && w_shift &&
                   (r_cpha || (r_cnt != '0))) begin
        r_miso <= r_tx[DWIDTH-1];
        r_tx   <= {r_tx[DWIDTH-2:0], 1'b0};
      end else if (w_state_nxt != RDATA) begin
        r_miso <= 1'b0;
      end
    end
  end

  // Register array; write merges the new low bits over the old word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is architecturally cleared by reset, so it is built
      // from flops with a reset loop rather than inferred RAM.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_wr_pend) begin
      r_mem[r_addr] <= (r_mem[r_addr] & ~w_mask) | (r_rx & w_mask);
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_armed & ~w_ss_q;
  assign wr_pulse  = r_wr_pulse;
  assign rd_pulse  = r_rd_pulse;
  assign frame_err = r_frame_err;
  assign dbg_rdata = r_mem[dbg_addr];

endmodule

// File: tb/tb_spi_2_slave.sv
`timescale 1ns/1ps
// Self-checking bench for spi_2_slave: directed frames plus randomised
// traffic compared against an array model of the register file.
module tb_spi_2_slave;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int TCLK = 10;
  localparam int HALF = 4 * TCLK;   // sclk = clk/8

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cfg   = 2'b00;
  logic          sclk  = 1'b0;
  logic          ss_n  = 1'b1;
  logic          mosi  = 1'b0;
  logic          miso, miso_oe, wr_pulse, rd_pulse, frame_err;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_rdata;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rd = 0, n_ferr = 0;

  logic [DW-1:0] model [256];

  always #(TCLK/2) clk = ~clk;

  spi_2_slave #(.DWIDTH(DW), .AWIDTH(AW), .SYNC_STG(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .wr_pulse  (wr_pulse),
    .rd_pulse  (rd_pulse),
    .frame_err (frame_err),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (wr_pulse)  n_wr++;
    if (rd_pulse)  n_rd++;
    if (frame_err) n_ferr++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_nb(input logic [1:0] size);
    int nb;
    nb = 8 << size;
    return (nb > DW) ? DW : nb;
  endfunction

  function automatic logic [63:0] nb_mask(input int nb);
    return (nb >= 64) ? '1 : ((64'(1) << nb) - 64'(1));
  endfunction

  // Bit-bang one frame as an SPI master; bits are sent from bit nbits-1 down.
  // rst_at >= 0 pulses rst_n before that bit and checks the outputs in reset.
  task automatic spi_frame(input logic [1:0] mode, input logic [127:0] bits,
                           input int nbits, input int rst_at, output logic [127:0] rx);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    rx   = '0;
    cfg  = mode;
    sclk = cpol;
    #(HALF);
    ss_n = 1'b0;
    if (!cpha) mosi = bits[nbits-1];
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #(2*TCLK);
        check("miso_in_reset", 64'(miso), 64'(0));
        check("miso_oe_in_reset", 64'(miso_oe), 64'(0));
        rst_n = 1'b1;
      end
      if (!cpha) begin
        #(HALF);
        rx[nbits-1-i] = miso;
        sclk = ~cpol;
        #(HALF);
        sclk = cpol;
        if (i + 1 < nbits) mosi = bits[nbits-2-i];
      end else begin
        #(HALF);
        sclk = ~cpol;
        mosi = bits[nbits-1-i];
        #(HALF);
        rx[nbits-1-i] = miso;
        sclk = cpol;
      end
    end
    #(HALF);
    ss_n = 1'b1;
    mosi = 1'b0;
    #(12*TCLK);
  endtask

  task automatic do_write(input string tag, input logic [1:0] mode, input logic [1:0] size,
                          input logic [7:0] addr, input logic [31:0] data, input int extra);
    int nb, w0, r0, f0;
    logic [127:0] fr, rx;
    logic [63:0]  m;
    nb = ref_nb(size);
    m  = nb_mask(nb);
    w0 = n_wr; r0 = n_rd; f0 = n_ferr;
    fr = {1'b1, size, addr};
    fr = (fr << nb) | (128'(data) & 128'(m));
    fr = fr << extra;
    spi_frame(mode, fr, 11 + nb + extra, -1, rx);
    model[addr] = (model[addr] & ~m[DW-1:0]) | (data & m[DW-1:0]);
    check({tag, "_wr_pulse"},  64'(n_wr - w0),   64'(1));
    check({tag, "_rd_pulse"},  64'(n_rd - r0),   64'(0));
    check({tag, "_frame_err"}, 64'(n_ferr - f0), 64'((extra > 4) ? 1 : 0));
    dbg_addr = addr;
    #1;
    check({tag, "_dbg"}, 64'(dbg_rdata), 64'(model[addr]));
  endtask

  task automatic do_read(input string tag, input logic [1:0] mode, input logic [1:0] size,
                         input logic [7:0] addr);
    int nb, w0, r0, f0;
    logic [127:0] fr, rx;
    logic [63:0]  m;
    nb = ref_nb(size);
    m  = nb_mask(nb);
    w0 = n_wr; r0 = n_rd; f0 = n_ferr;
    fr = {1'b0, size, addr};
    fr = fr << nb;
    spi_frame(mode, fr, 11 + nb, -1, rx);
    check({tag, "_rdata"},     rx[63:0] & m,     64'(model[addr]) & m);
    check({tag, "_rd_pulse"},  64'(n_rd - r0),   64'(1));
    check({tag, "_wr_pulse"},  64'(n_wr - w0),   64'(0));
    check({tag, "_frame_err"}, 64'(n_ferr - f0), 64'(0));
    check({tag, "_miso_idle"}, 64'(miso),        64'(0));
  endtask

  initial begin
    logic [127:0] fr, rx;
    logic [1:0]   md, sz;
    logic [7:0]   ad;
    int           w0, r0, f0;

    for (int i = 0; i < 256; i++) model[i] = '0;

    // Reset state
    #3;
    #(3*TCLK);
    dbg_addr = 8'h12;
    #1;
    check("rst_miso",      64'(miso),      64'(0));
    check("rst_miso_oe",   64'(miso_oe),   64'(0));
    check("rst_wr_pulse",  64'(wr_pulse),  64'(0));
    check("rst_rd_pulse",  64'(rd_pulse),  64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_dbg",       64'(dbg_rdata), 64'(0));
    #(TCLK - 1);
    rst_n = 1'b1;
    #(6*TCLK);

    // Full-word write then read back, mode 0
    do_write("t1_wr", 2'b00, 2'b11, 8'h12, 32'hDEADBEEF, 0);
    do_read ("t2_rd", 2'b00, 2'b11, 8'h12);

    // Byte write keeps the upper bits; halfword read
    do_write("t3_wr", 2'b00, 2'b00, 8'h12, 32'h00000055, 0);
    check("t3_model", 64'(model[8'h12]), 64'(32'hDEADBE55));
    do_read ("t3_rd", 2'b00, 2'b01, 8'h12);

    // Round trip in every mode at the top address
    for (int m = 0; m < 4; m++) begin
      do_write("t4_wr", 2'(m), 2'b11, 8'hFF, 32'hA5A5_0F0F ^ 32'(m), 0);
      do_read ("t4_rd", 2'(m), 2'b11, 8'hFF);
    end

    // ss_n rises after 20 data bits: error pulse, no write, next frame fine
    w0 = n_wr; f0 = n_ferr;
    fr = {1'b1, 2'b11, 8'h12};
    fr = (fr << 20) | 128'(20'hABCDE);
    spi_frame(2'b00, fr, 31, -1, rx);
    check("t5_frame_err", 64'(n_ferr - f0), 64'(1));
    check("t5_no_write",  64'(n_wr - w0),   64'(0));
    dbg_addr = 8'h12;
    #1;
    check("t5_mem_kept",  64'(dbg_rdata),   64'(model[8'h12]));
    do_read("t5_next", 2'b00, 2'b11, 8'h12);

    // Trailing samples in DONE: four tolerated, five flagged
    do_write("ovr4", 2'b01, 2'b10, 8'h40, 32'h1234_5678, 4);
    do_write("ovr5", 2'b10, 2'b10, 8'h41, 32'h8765_4321, 5);

    // Randomised traffic over a small address pool
    for (int n = 0; n < 30; n++) begin
      md = 2'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      ad = 8'($urandom_range(0, 7)) | ((($urandom & 1) != 0) ? 8'hF8 : 8'h00);
      if (($urandom & 1) != 0) do_write("rnd_wr", md, sz, ad, 32'($urandom), 0);
      else                     do_read ("rnd_rd", md, sz, ad);
    end

    // Reset in the middle of a read: abort silently, array cleared
    w0 = n_wr; r0 = n_rd; f0 = n_ferr;
    fr = {1'b0, 2'b11, 8'h12};
    fr = fr << 32;
    spi_frame(2'b00, fr, 43, 21, rx);
    for (int i = 0; i < 256; i++) model[i] = '0;
    check("t6_rd_before_rst", 64'(n_rd - r0),   64'(1));
    check("t6_no_write",      64'(n_wr - w0),   64'(0));
    check("t6_no_frame_err",  64'(n_ferr - f0), 64'(0));
    dbg_addr = 8'hFF;
    #1;
    check("t6_cleared_ff", 64'(dbg_rdata), 64'(0));
    do_read("t6_rd", 2'b00, 2'b11, 8'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
